cmplx_twiddle_mult: RTL and testbench

Pipelined, parametrised complex fixed-point multiplier for the 32-point FFT butterfly datapath. It multiplies a complex sample by a complex twiddle factor, supports a conjugate-twiddle mode for the inverse transform, and rounds and saturates the result back to sample width. A valid bit travels alongside the data, and a clock enable stalls the whole pipeline. It sits between the butterfly output and the next stage's input registers, and supersedes the scalar real multiplier in that path.

---
 rtl/cmplx_twiddle_mult.sv | 154 +++++++++++++++
 tb/tb_cmplx_twiddle_mult.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_twiddle_mult.sv
// Four-stage complex multiplier (sample x twiddle or sample x conj(twiddle)) with
// round-half-up, saturation to sample width, a travelling valid bit and a sticky overflow flag.
module cmplx_twiddle_mult #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16
) (
    input  logic                     clk,
    input  logic                     aclr,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic                     conj,
    input  logic signed [DATA_W-1:0] data_re,
    input  logic signed [DATA_W-1:0] data_im,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     ovf
);

    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] RND = {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
    localparam logic signed [SW-1:0] HI  = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SW-1:0] LO  = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] a_q, b_q;
    logic signed [TW_W-1:0]   c_q, d_q;
    logic                     conj1, v1;

    logic signed [PW-1:0]     a_x, b_x, c_x, d_x;
    logic signed [PW-1:0]     p_ac, p_bd, p_ad, p_bc;
    logic                     conj2, v2;

    logic signed [SW-1:0]     ac_x, bd_x, ad_x, bc_x;
    logic signed [SW-1:0]     sum_re_d, sum_im_d;
    logic signed [SW-1:0]     sum_re, sum_im;
    logic                     v3;

    logic signed [SW-1:0]     shr_re, shr_im;
    logic signed [DATA_W-1:0] sat_re, sat_im;
    logic                     hit_re, hit_im, sat_any;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            conj1 <= 1'b0;
            v1    <= 1'b0;
        end else if (en) begin
            a_q   <= data_re;
            b_q   <= data_im;
            c_q   <= tw_re;
            d_q   <= tw_im;
            conj1 <= conj;
            v1    <= in_valid;
        end
    end

    // Operands sign-extended to full product width so each product is exact.
    assign a_x = {{TW_W{a_q[DATA_W-1]}}, a_q};
    assign b_x = {{TW_W{b_q[DATA_W-1]}}, b_q};
    assign c_x = {{DATA_W{c_q[TW_W-1]}}, c_q};
    assign d_x = {{DATA_W{d_q[TW_W-1]}}, d_q};

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            p_ac  <= '0;
            p_bd  <= '0;
            p_ad  <= '0;
            p_bc  <= '0;
            conj2 <= 1'b0;
            v2    <= 1'b0;
        end else if (en) begin
            p_ac  <= a_x * c_x;
            p_bd  <= b_x * d_x;
            p_ad  <= a_x * d_x;
            p_bc  <= b_x * c_x;
            conj2 <= conj1;
            v2    <= v1;
        end
    end

    assign ac_x = {p_ac[PW-1], p_ac};
    assign bd_x = {p_bd[PW-1], p_bd};
    assign ad_x = {p_ad[PW-1], p_ad};
    assign bc_x = {p_bc[PW-1], p_bc};

    // Conjugation only swaps add/subtract; the twiddle itself is never negated.
    always_comb begin
        sum_re_d = ac_x - bd_x;
        sum_im_d = ad_x + bc_x;
        if (conj2) begin
            sum_re_d = ac_x + bd_x;
            sum_im_d = bc_x - ad_x;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            sum_re <= '0;
            sum_im <= '0;
            v3     <= 1'b0;
        end else if (en) begin
            sum_re <= sum_re_d;
            sum_im <= sum_im_d;
            v3     <= v2;
        end
    end

    assign shr_re = (sum_re + RND) >>> (TW_W - 1);
    assign shr_im = (sum_im + RND) >>> (TW_W - 1);

    always_comb begin
        hit_re = (shr_re > HI) || (shr_re < LO);
        hit_im = (shr_im > HI) || (shr_im < LO);
        sat_re = shr_re[DATA_W-1:0];
        sat_im = shr_im[DATA_W-1:0];
        if (shr_re > HI) sat_re = HI[DATA_W-1:0];
        if (shr_re < LO) sat_re = LO[DATA_W-1:0];
        if (shr_im > HI) sat_im = HI[DATA_W-1:0];
        if (shr_im < LO) sat_im = LO[DATA_W-1:0];
        sat_any = v3 && (hit_re || hit_im);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            out_re    <= '0;
            out_im    <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out_re    <= sat_re;
            out_im    <= sat_im;
            out_valid <= v3;
        end
    end

    // Set has priority over clear; clear works even while the pipeline is stalled.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            ovf <= 1'b0;
        end else if (en && sat_any) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmplx_twiddle_mult.sv
// Bench for cmplx_twiddle_mult: fixed vector table, ovf corner sequences, a randomized
// stream with a stall checked against an arithmetic reference, and mid-flight reset.
module tb_cmplx_twiddle_mult;

    localparam int DW = 16;
    localparam int TW = 16;

    logic                 clk = 1'b0;
    logic                 aclr, en, in_valid, conj, ovf_clr;
    logic signed [DW-1:0] data_re, data_im;
    logic signed [TW-1:0] tw_re, tw_im;
    logic                 out_valid, ovf;
    logic signed [DW-1:0] out_re, out_im;

    int n_tests = 0;
    int n_fail  = 0;

    cmplx_twiddle_mult #(.DATA_W(DW), .TW_W(TW)) dut (
        .clk(clk), .aclr(aclr), .en(en), .in_valid(in_valid), .conj(conj),
        .data_re(data_re), .data_im(data_im), .tw_re(tw_re), .tw_im(tw_im),
        .ovf_clr(ovf_clr), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a, b, c, d;
        bit cj;
        int exp_re, exp_im;
        bit exp_ovf;
    } vec_t;

    typedef struct {
        int re, im;
    } exp_t;

    vec_t vecs[6];
    exp_t q[$];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, b, c, d, input bit cj);
        data_re = a[DW-1:0];
        data_im = b[DW-1:0];
        tw_re   = c[TW-1:0];
        tw_im   = d[TW-1:0];
        conj    = cj;
    endtask

    // Exact integer arithmetic, floor(x/2^(TW-1) + 1/2), then clamp.
    function automatic int round_sat(input longint x, inout bit sat);
        longint y;
        y = (x + (longint'(1) << (TW - 2))) >>> (TW - 1);
        if (y > (longint'(1) << (DW - 1)) - 1) begin
            sat = 1'b1;
            y = (longint'(1) << (DW - 1)) - 1;
        end else if (y < -(longint'(1) << (DW - 1))) begin
            sat = 1'b1;
            y = -(longint'(1) << (DW - 1));
        end
        return int'(y);
    endfunction

    task automatic ref_mult(input int a, b, c, d, input bit cj,
                            output int re, output int im, output bit sat);
        longint ac, bd, ad, bc;
        ac = longint'(a) * c;
        bd = longint'(b) * d;
        ad = longint'(a) * d;
        bc = longint'(b) * c;
        sat = 1'b0;
        re = round_sat(cj ? ac + bd : ac - bd, sat);
        im = round_sat(cj ? bc - ad : ad + bc, sat);
    endtask

    task automatic apply_vec(input int k);
        drive(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].d, vecs[k].cj);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check($sformatf("v%0d_early_valid", k), out_valid, 0);
        step();
        check($sformatf("v%0d_valid", k), out_valid, 1);
        check($sformatf("v%0d_re", k), out_re, vecs[k].exp_re);
        check($sformatf("v%0d_im", k), out_im, vecs[k].exp_im);
        check($sformatf("v%0d_ovf", k), ovf, vecs[k].exp_ovf);
    endtask

    initial begin
        int sent, popped, m_re, m_im, stale;
        bit m_sat, m_ovf, cur_en;
        logic signed [DW-1:0] hold_re;
        logic hold_v;
        int ra, rb, rc, rd;

        vecs[0] = '{1000, -2000, 32767, 0,     1'b0,  1000, -2000, 1'b0};
        vecs[1] = '{1000, -2000, 0,     32767, 1'b0,  2000,  1000, 1'b0};
        vecs[2] = '{1000, -2000, 0,     32767, 1'b1, -2000, -1000, 1'b0};
        vecs[3] = '{0,    1000,  0,     32767, 1'b1,  1000,     0, 1'b0};
        vecs[4] = '{0,    1000,  0,     32767, 1'b0, -1000,     0, 1'b0};
        vecs[5] = '{-32768, -32768, -32768, 0, 1'b0, 32767, 32767, 1'b1};

        aclr = 1'b1; en = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0;
        drive(0, 0, 0, 0, 1'b0);
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        check("rst_ovf", ovf, 0);
        #10 aclr = 1'b0;
        step();

        for (int k = 0; k < 6; k++) apply_vec(k);

        // Sticky ovf, then a clear while stalled.
        step(); step(); step();
        check("ovf_sticky", ovf, 1);
        en = 1'b0; ovf_clr = 1'b1;
        step();
        check("ovf_clr_stalled", ovf, 0);
        en = 1'b1; ovf_clr = 1'b0;

        // Clear held through a saturating word: set must win.
        ovf_clr = 1'b1;
        apply_vec(5);
        ovf_clr = 1'b0;
        step();
        check("ovf_set_wins_hold", ovf, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Random stream with a three-cycle stall.
        sent = 0; popped = 0; m_ovf = 1'b0;
        hold_re = out_re; hold_v = out_valid;
        for (int cyc = 0; cyc < 40 && (sent < 8 || q.size() > 0); cyc++) begin
            cur_en = !(cyc >= 4 && cyc <= 6);
            en = cur_en;
            ra = $signed(16'($urandom)); rb = $signed(16'($urandom));
            rc = $signed(16'($urandom)); rd = $signed(16'($urandom));
            if (sent == 2) begin
                ra = -32768; rb = -32768; rc = -32768; rd = 0;
            end
            drive(ra, rb, rc, rd, sent[0]);
            in_valid = (sent < 8);
            if (cur_en && sent < 8) begin
                ref_mult(ra, rb, rc, rd, sent[0], m_re, m_im, m_sat);
                q.push_back('{m_re, m_im});
                m_ovf |= m_sat;
                sent++;
            end
            step();
            if (cur_en) begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("stream_extra_valid", out_valid, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        popped++;
                        check($sformatf("stream%0d_re", popped), out_re, e.re);
                        check($sformatf("stream%0d_im", popped), out_im, e.im);
                    end
                end
            end else begin
                check($sformatf("stall%0d_valid", cyc), out_valid, hold_v);
                check($sformatf("stall%0d_re", cyc), out_re, hold_re);
            end
            hold_re = out_re; hold_v = out_valid;
        end
        in_valid = 1'b0; en = 1'b1;
        check("stream_count", popped, 8);
        check("stream_q_empty", q.size(), 0);
        check("stream_ovf", ovf, m_ovf);
        step(); step(); step(); step();
        check("stream_no_dup", out_valid, 0);

        // Saturating word at the output with three more samples in flight, then reset.
        drive(-32768, -32768, -32768, 0, 1'b0);
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            drive(100 * (i + 1), 50, 16384, 8192, i[0]);
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_ovf", ovf, 1);
        #2 aclr = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_re", out_re, 0);
        check("mid_rst_im", out_im, 0);
        check("mid_rst_ovf", ovf, 0);
        #3 aclr = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) stale++;
        end
        check("post_rst_stale", stale, 0);

        apply_vec(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
